// File: rtl/cpu_types_pkg.sv
// ============================================================================
//  Module   : cpu_types_pkg
//  Purpose  : Shared CPU-wide types: memory word and RAM handshake state.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_pkg.sv
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Arbiter state encoding, default sizing and width helper.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 64;
    localparam int REQID_W     = $clog2(DEF_NREQ);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Width needed to index n items; never returns zero.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin pick: first set bit at or after ptr,
//             wrapping around the request vector.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker
    import ram_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = id_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    always_comb begin : p_pick
        int j;
        o_valid = |i_req;
        o_idx   = '0;
        j       = 0;
        // Scan from the farthest offset down so the nearest hit wins.
        for (int off = N - 1; off >= 0; off--) begin
            j = (int'(i_ptr) + off) % N;
            if (i_req[j]) begin
                o_idx = W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Round-robin arbiter sharing one RAM port among NREQ cache
//             requesters, one transaction in flight, with a BUSY timeout.
//             Optional macro RAM_ARB_DPRIO_EN gives dcache (odd) requesters
//             priority over icache (even) requesters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import cpu_types_pkg::*;
    import ram_arb_pkg::*;
#(
    parameter  int NREQ    = DEF_NREQ,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W    = id_width(NREQ)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_ren,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_store,
    output logic [NREQ-1:0]      req_wait,
    output logic [31:0]          req_load,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int              c_TMR_W    = id_width(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] c_ID_LAST  = ID_W'(NREQ - 1);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [c_TMR_W-1:0]  r_timer;

    logic [NREQ-1:0]     w_active;
    logic [NREQ-1:0]     w_pick_vec;
    logic                w_pick_valid;
    logic [ID_W-1:0]     w_pick_idx;
    logic [ID_W-1:0]     w_next_ptr;

    ramstate_t           w_rs;
    logic                w_xfer;
    logic                w_sel_ren;
    logic                w_sel_wen;
    word_t               w_sel_addr;
    word_t               w_sel_store;
    logic                w_done;
    logic                w_drop;
    logic                w_abort;

    assign w_active = req_ren | req_wen;
    assign w_rs     = ramstate_t'(ramstate);
    assign w_xfer   = (r_state == XFER);

`ifdef RAM_ARB_DPRIO_EN
    logic [NREQ-1:0] w_odd_mask;
    logic [NREQ-1:0] w_odd_active;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_odd_mask
        assign w_odd_mask[gi] = ((gi % 2) == 1);
    end

    assign w_odd_active = w_active & w_odd_mask;
    assign w_pick_vec   = (|w_odd_active) ? w_odd_active : w_active;
`else
    assign w_pick_vec   = w_active;
`endif

    rr_picker #(
        .N       (NREQ)
    ) u_rr_picker (
        .i_req   (w_pick_vec),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Route the granted requester's signals onto the RAM side.
    always_comb begin
        w_sel_ren   = 1'b0;
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_store = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant == ID_W'(i)) begin
                w_sel_ren   = req_ren[i];
                w_sel_wen   = req_wen[i];
                w_sel_addr  = req_addr[i*32 +: 32];
                w_sel_store = req_store[i*32 +: 32];
            end
        end
    end

    assign w_done  = w_xfer & (w_rs == ACCESS);
    assign w_drop  = w_xfer & ~w_done & ~(w_sel_ren | w_sel_wen);
    assign w_abort = w_xfer & ~w_done & ~w_drop &
                     ((r_timer == c_TMR_LAST) | (w_rs == ERROR));

    assign w_next_ptr = (r_grant == c_ID_LAST) ? '0 : r_grant + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_timer <= '0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_done) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end else if (w_drop) begin
                        r_state  <= IDLE;
                    end else if (w_abort) begin
                        // Skip past the stalled requester so others get a turn.
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end else begin
                        r_timer  <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_wait = w_active;
        if (w_done) begin
            req_wait[r_grant] = 1'b0;
        end
        if (RST) begin
            req_wait = '1;
        end
    end

    assign req_load    = w_done ? ramload : '0;
    assign ramWEN      = w_xfer & w_sel_wen;
    assign ramREN      = w_xfer & w_sel_ren & ~w_sel_wen;
    assign ramaddr     = w_xfer ? w_sel_addr  : '0;
    assign ramstore    = w_xfer ? w_sel_store : '0;
    assign grant_id    = r_grant;
    assign busy        = w_xfer;
    assign timeout_err = w_abort;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed self-checking bench for ram_arbiter (NREQ=4,
//             TIMEOUT=64) with a small latency-programmable RAM model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic         CLK;
    logic         RST;
    logic [3:0]   req_ren;
    logic [3:0]   req_wen;
    logic [127:0] req_addr;
    logic [127:0] req_store;
    logic [3:0]   req_wait;
    logic [31:0]  req_load;
    logic         ramREN;
    logic         ramWEN;
    logic [31:0]  ramaddr;
    logic [31:0]  ramstore;
    logic [31:0]  ramload;
    logic [1:0]   ramstate;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // RAM model controls
    int   ram_lat  = 2;
    bit   ram_hang = 1'b0;
    bit   ram_err  = 1'b0;
    int   ram_cnt  = 0;
    logic [31:0] mem [0:1023];
    bit          written [0:1023];

    // Completion log filled by run_cycles
    int          done_n;
    int          done_id   [0:15];
    int          done_cyc  [0:15];
    logic [31:0] done_load [0:15];
    logic [1:0]  done_gid  [0:15];
    logic        done_ren  [0:15];
    logic        done_wen  [0:15];
    logic [31:0] done_addr [0:15];
    logic [31:0] done_store[0:15];
    int          to_n;
    int          to_cyc;

    ram_arbiter #(
        .NREQ        (4),
        .TIMEOUT     (64)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_ren     (req_ren),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_store   (req_store),
        .req_wait    (req_wait),
        .req_load    (req_load),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        if (!(ramREN | ramWEN))                  ramstate = 2'd0;
        else if (ram_err)                        ramstate = 2'd3;
        else if (!ram_hang && ram_cnt >= ram_lat) ramstate = 2'd2;
        else                                     ramstate = 2'd1;
    end

    always @(posedge CLK) begin
        if ((ramREN | ramWEN) && ramstate == 2'd2) begin
            if (ramWEN) begin
                mem[ramaddr[9:0]]     <= ramstore;
                written[ramaddr[9:0]] <= 1'b1;
            end
            ram_cnt <= 0;
        end else if (ramREN | ramWEN) begin
            ram_cnt <= ram_cnt + 1;
        end else begin
            ram_cnt <= 0;
        end
    end

    assign ramload = written[ramaddr[9:0]] ? mem[ramaddr[9:0]]
                                           : (32'hC0DE_0000 | {22'd0, ramaddr[9:0]});

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Run ncyc cycles: sample at negedge, log completions, release finished
    // requesters just after the following posedge.
    task automatic run_cycles(input int ncyc);
        logic [3:0] m;
        done_n = 0;
        to_n   = 0;
        to_cyc = -1;
        for (int k = 0; k < 16; k++) begin
            done_id[k]  = -1;
            done_cyc[k] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            m = (req_ren | req_wen) & ~req_wait;
            if (timeout_err) begin
                to_n++;
                if (to_cyc < 0) to_cyc = c;
            end
            for (int i = 0; i < 4; i++) begin
                if (m[i] && done_n < 16) begin
                    done_id[done_n]    = i;
                    done_cyc[done_n]   = c;
                    done_load[done_n]  = req_load;
                    done_gid[done_n]   = grant_id;
                    done_ren[done_n]   = ramREN;
                    done_wen[done_n]   = ramWEN;
                    done_addr[done_n]  = ramaddr;
                    done_store[done_n] = ramstore;
                    done_n++;
                end
            end
            @(posedge CLK);
            #1;
            req_ren = req_ren & ~m;
            req_wen = req_wen & ~m;
        end
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_store = '0;
        repeat (3) @(negedge CLK);
        n_checks++; if (req_wait !== 4'hF) begin n_errors++; $display("FAIL reset_wait: got %h expected %h", req_wait, 4'hF); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_checks++; if ({ramREN, ramWEN, timeout_err} !== 3'b000) begin n_errors++; $display("FAIL reset_outs: got %b expected 000", {ramREN, ramWEN, timeout_err}); end
        n_checks++; if (req_load !== 32'h0) begin n_errors++; $display("FAIL reset_load: got %h expected 0", req_load); end
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_round_robin();
        int          exp_cyc  [0:3] = '{3, 7, 11, 15};
        logic [31:0] exp_load [0:3] = '{32'hC0DE0020, 32'hC0DE0021, 32'hC0DE0022, 32'hC0DE0023};
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h20 + i;
        req_ren = 4'hF;
        run_cycles(18);
        n_checks++; if (done_n !== 4) begin n_errors++; $display("FAIL rr_count: got %0d expected 4", done_n); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (done_id[k] !== k) begin n_errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, done_id[k], k); end
            n_checks++; if (done_cyc[k] !== exp_cyc[k]) begin n_errors++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", k, done_cyc[k], exp_cyc[k]); end
            n_checks++; if (done_load[k] !== exp_load[k]) begin n_errors++; $display("FAIL rr_load[%0d]: got %h expected %h", k, done_load[k], exp_load[k]); end
            n_checks++; if (done_gid[k] !== 2'(k)) begin n_errors++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", k, done_gid[k], k); end
        end
    endtask

    task automatic test_write_read();
        // Requester 1 raises both ren and wen: the write must win.
        req_addr[32 +: 32]  = 32'h100;
        req_store[32 +: 32] = 32'hDEADBEEF;
        req_wen[1] = 1'b1;
        req_ren[1] = 1'b1;
        run_cycles(6);
        n_checks++; if (done_id[0] !== 1 || done_cyc[0] !== 3) begin n_errors++; $display("FAIL wr_done: got id %0d cyc %0d expected id 1 cyc 3", done_id[0], done_cyc[0]); end
        n_checks++; if ({done_wen[0], done_ren[0]} !== 2'b10) begin n_errors++; $display("FAIL wr_enables: got wen/ren %b expected 10", {done_wen[0], done_ren[0]}); end
        n_checks++; if (done_addr[0] !== 32'h100 || done_store[0] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_bus: got addr %h data %h expected 100 deadbeef", done_addr[0], done_store[0]); end
        req_addr[64 +: 32] = 32'h100;
        req_ren[2] = 1'b1;
        run_cycles(6);
        n_checks++; if (done_id[0] !== 2 || done_cyc[0] !== 3) begin n_errors++; $display("FAIL rd_done: got id %0d cyc %0d expected id 2 cyc 3", done_id[0], done_cyc[0]); end
        n_checks++; if ({done_wen[0], done_ren[0]} !== 2'b01) begin n_errors++; $display("FAIL rd_enables: got wen/ren %b expected 01", {done_wen[0], done_ren[0]}); end
        n_checks++; if (done_load[0] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL rd_load: got %h expected deadbeef", done_load[0]); end
    endtask

    task automatic test_rr_wrap();
        // Pointer sits at 3 after requester 2 completed.
        req_addr[0 +: 32]  = 32'h30;
        req_addr[96 +: 32] = 32'h33;
        req_ren = 4'b1001;
        run_cycles(10);
        n_checks++; if (done_id[0] !== 3 || done_id[1] !== 0) begin n_errors++; $display("FAIL wrap_order: got %0d,%0d expected 3,0", done_id[0], done_id[1]); end
        n_checks++; if (done_load[0] !== 32'hC0DE0033 || done_load[1] !== 32'hC0DE0030) begin n_errors++; $display("FAIL wrap_load: got %h,%h expected c0de0033,c0de0030", done_load[0], done_load[1]); end
    endtask

    task automatic test_timeout();
        ram_hang = 1'b1;
        req_addr[32 +: 32] = 32'h41;
        req_ren[1] = 1'b1;
        run_cycles(66);
        n_checks++; if (to_cyc !== 64) begin n_errors++; $display("FAIL to_cycle: got %0d expected 64", to_cyc); end
        n_checks++; if (to_n !== 1) begin n_errors++; $display("FAIL to_pulses: got %0d expected 1", to_n); end
        n_checks++; if (done_n !== 0) begin n_errors++; $display("FAIL to_no_done: got %0d expected 0", done_n); end
        ram_hang = 1'b0;
        run_cycles(6);
        n_checks++; if (done_id[0] !== 1 || done_cyc[0] !== 2 || done_gid[0] !== 2'd1) begin n_errors++; $display("FAIL to_regrant: got id %0d cyc %0d gid %0d expected 1 2 1", done_id[0], done_cyc[0], done_gid[0]); end
    endtask

    task automatic test_error();
        ram_err = 1'b1;
        req_addr[0 +: 32] = 32'h50;
        req_ren[0] = 1'b1;
        run_cycles(3);
        n_checks++; if (to_cyc !== 1 || to_n !== 1) begin n_errors++; $display("FAIL err_abort: got cyc %0d pulses %0d expected 1 1", to_cyc, to_n); end
        ram_err = 1'b0;
        run_cycles(6);
        n_checks++; if (done_id[0] !== 0 || done_cyc[0] !== 2 || done_load[0] !== 32'hC0DE0050) begin n_errors++; $display("FAIL err_retry: got id %0d cyc %0d load %h expected 0 2 c0de0050", done_id[0], done_cyc[0], done_load[0]); end
    endtask

    task automatic test_drop();
        req_addr[64 +: 32] = 32'h60;
        req_ren[2] = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (ramREN !== 1'b1 || grant_id !== 2'd2) begin n_errors++; $display("FAIL drop_x1: got ren %b gid %0d expected 1 2", ramREN, grant_id); end
        @(posedge CLK); #1;
        req_ren[2] = 1'b0;
        @(negedge CLK);
        n_checks++; if ({ramREN, ramWEN, busy, timeout_err} !== 4'b0010) begin n_errors++; $display("FAIL drop_x2: got ren/wen/busy/to %b expected 0010", {ramREN, ramWEN, busy, timeout_err}); end
        n_checks++; if (req_wait !== 4'h0) begin n_errors++; $display("FAIL drop_wait: got %h expected 0", req_wait); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_errors++; $display("FAIL drop_idle: got busy %b to %b expected 0 0", busy, timeout_err); end
        @(posedge CLK); #1;
        // Pointer must still be 1, so requester 2 is ahead of requester 0.
        req_addr[0 +: 32] = 32'h61;
        req_ren = 4'b0101;
        run_cycles(10);
        n_checks++; if (done_id[0] !== 2 || done_id[1] !== 0) begin n_errors++; $display("FAIL drop_ptr: got %0d,%0d expected 2,0", done_id[0], done_id[1]); end
    endtask

    task automatic test_reset_mid_xfer();
        req_addr[96 +: 32] = 32'h73;
        req_ren[3] = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b1 || ramREN !== 1'b1 || grant_id !== 2'd3) begin n_errors++; $display("FAIL mid_pre: got busy %b ren %b gid %0d expected 1 1 3", busy, ramREN, grant_id); end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || ramREN !== 1'b0 || req_wait !== 4'hF || grant_id !== 2'd0) begin n_errors++; $display("FAIL mid_rst: got busy %b ren %b wait %h gid %0d expected 0 0 f 0", busy, ramREN, req_wait, grant_id); end
        RST = 1'b0;
        @(posedge CLK); #1;
        run_cycles(5);
        n_checks++; if (done_id[0] !== 3 || done_cyc[0] !== 2) begin n_errors++; $display("FAIL mid_rearb: got id %0d cyc %0d expected 3 2", done_id[0], done_cyc[0]); end
    endtask

    task automatic test_dprio();
        int exp_first;
        int exp_second;
`ifdef RAM_ARB_DPRIO_EN
        exp_first  = 1;
        exp_second = 0;
`else
        exp_first  = 0;
        exp_second = 1;
`endif
        req_addr[0 +: 32]  = 32'h80;
        req_addr[32 +: 32] = 32'h81;
        req_ren = 4'b0011;
        run_cycles(10);
        n_checks++; if (done_id[0] !== exp_first || done_id[1] !== exp_second) begin n_errors++; $display("FAIL prio_order: got %0d,%0d expected %0d,%0d", done_id[0], done_id[1], exp_first, exp_second); end
        n_checks++; if (done_cyc[0] !== 3 || done_cyc[1] !== 7) begin n_errors++; $display("FAIL prio_cycles: got %0d,%0d expected 3,7", done_cyc[0], done_cyc[1]); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_rr_wrap();
        test_timeout();
        test_error();
        test_drop();
        test_reset_mid_xfer();
        test_dprio();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
